// File: rtl/spi_config_master_if.sv
// Command handshake between a write-command producer and spi_config_master.
// The producer drives {cmd_addr, cmd_data} with cmd_valid; the controller answers with cmd_ready.
interface spi_config_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_config_master.sv
// SPI mode-0 write master: buffers 16-bit register-write frames in a small FIFO and
// shifts them out MSB first with programmable ncs setup/hold, sclk half-period and idle gap.
module spi_config_master #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int IDLE_GAP   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_config_master_if.slave            cmd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ncs,
    output logic                          sclk,
    output logic                          copi
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
    localparam logic [AW:0]      FULL_LVL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             phase, phase_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic             load, shift_en;

    logic [14:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level, level_nxt;
    logic             push, pop;
    logic [15:0]      shreg;

    assign push       = cmd.cmd_valid && cmd.cmd_ready;
    assign pop        = load;
    assign level_nxt  = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd.cmd_addr, cmd.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
        end
    end

    // Frame shift register: write bit and address/data, consumed MSB first on each sclk fall.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= {1'b1, fifo_mem[rd_ptr]};
        end else if (shift_en) begin
            shreg <= {shreg[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        load        = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (level != '0) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt     = '0;
                    phase_nxt   = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (!phase) begin
                        phase_nxt = 1'b1;
                    end else if (bit_cnt == 4'd15) begin
                        phase_nxt = 1'b0;
                        state_nxt = HOLD;
                    end else begin
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        shift_en    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (level != '0) begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Every pin is a flop decoded from the current state, so pins trail the state by one
    // cycle uniformly; this keeps all phase lengths exact and the pins glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs           <= 1'b1;
            sclk          <= 1'b0;
            copi          <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
        end else begin
            ncs           <= !((state == SETUP) || (state == SHIFT) || (state == HOLD));
            sclk          <= (state == SHIFT) && phase;
            copi          <= (state == IDLE) ? 1'b0 : shreg[15];
            done          <= (state == GAP) && (cnt == '0);
            busy          <= (state != IDLE) || (level != '0);
            cmd.cmd_ready <= (level_nxt != FULL_LVL);
        end
    end
endmodule

// File: doc/spi_config_master.md
Name: spi_config_master

Overview:
- Host-side SPI write controller that sequences 16-bit write frames into the chip's SPI register-file peripheral.
- Targets the output-enable, PWM-enable and PWM duty-cycle registers.
- Accepts write commands over a valid/ready interface, buffers them in a small FIFO, and generates ncs/sclk/copi with programmable timing.
- Sits in the test/bring-up harness and in any on-chip sequencer that must reconfigure the peripheral.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; legal range >= 3, so the peripheral's 2-flop synchroniser sees every edge.
- FIFO_DEPTH, 4: command FIFO entries; power of two, >= 2.
- CS_SETUP, 2: clk cycles from ncs fall to start of the bit-0 low phase; >= 1.
- CS_HOLD, 2: clk cycles from the final sclk fall to ncs rise; >= 1.
- IDLE_GAP, 4: clk cycles ncs stays high between frames; >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full (registered)
- cmd_addr  input  7  register address (0x00-0x04 are defined; others are sent unchanged)
- cmd_data  input  8  write data
- busy  output  1  high while FSM is not IDLE or FIFO is non-empty
- done  output  1  one-cycle pulse, asserted in the same cycle ncs rises
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently buffered
- ncs  output  1  chip select, active low
- sclk  output  1  serial clock, idles low (mode 0)
- copi  output  1  serial data to peripheral

Behaviour:
- Reset (async, rst_n low): ncs=1, sclk=0, copi=0, done=0, busy=0, cmd_ready=1, fifo_level=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - A frame in progress is abandoned immediately; no partial frame is resumed after reset.
- Push: on a clk edge with cmd_valid && cmd_ready, the entry {cmd_addr, cmd_data} is written.
  - cmd_ready is not combinationally freed by a same-cycle pop. A pop in a full cycle raises cmd_ready on the next cycle.
- Frame format (16 bits, MSB first): bit15 = 1 (write), bits14:8 = cmd_addr, bits7:0 = cmd_data.
- Mode 0 timing: copi changes only while sclk is low, at the start of each low phase. The peripheral samples on the sclk rising edge.
- FSM states:
  - IDLE: ncs=1, sclk=0. If the FIFO is non-empty, pop into the 16-bit shift register, drive copi = frame bit15, and go to SETUP.
  - SETUP: ncs=0 for CS_SETUP cycles, then go to SHIFT.
  - SHIFT: 16 bits, each taking a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
    - The bit counter (0..15) increments at each high-to-low transition, which updates copi to the next bit.
    - After bit 15's high phase, sclk returns low and the FSM goes to HOLD.
  - HOLD: ncs=0, sclk=0, copi holds its last value for CS_HOLD cycles. Then ncs=1, done pulses, and the FSM goes to GAP.
  - GAP: ncs=1 for IDLE_GAP cycles. Then, if the FIFO is non-empty, pop and go directly to SETUP (same action as IDLE); otherwise go to IDLE with copi=0.
- Latency: with IDLE and an empty FIFO, ncs falls on the 2nd rising clk edge after the accepting edge.
- Per-frame timing:
  - ncs low duration = CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (132 at defaults).
  - Exactly 16 sclk rising edges per frame.
  - Frame-to-frame ncs-high time = IDLE_GAP cycles, i.e. ncs rise to next ncs fall.
- Full FIFO: cmd_ready=0 and cmd_valid is ignored; no overwrite occurs. Empty FIFO in GAP/IDLE results in no frame.
- busy falls only when IDLE is reached with the FIFO empty.
- All outputs are driven directly from flops (no glitches on ncs/sclk/copi).

Test Plan:
- Single write: addr 0x04, data 0x80.
  - Expected copi sequence at the 16 sclk rises: 1,0000100,10000000.
  - ncs low for exactly 132 clk cycles; one done pulse; busy returns low.
- Peripheral loopback: instantiate the SPI peripheral on the same clk, write addr 0x00=0xA5, 0x02=0x3C, 0x04=0xFF.
  - en_reg_out_7_0=0xA5, en_reg_pwm_7_0=0x3C and pwm_duty_cycle=0xFF after the third done.
- Back-to-back: push 6 commands on consecutive cycles with the controller idle.
  - The first 5 are accepted (1 popped + 4 buffered); cmd_ready is low on the 6th.
  - The 6th is accepted the cycle after the next pop.
  - 6 frames are sent in order, separated by exactly 4 ncs-high cycles.
- Reset mid-frame: assert rst_n low at sclk edge 7 of a frame.
  - ncs=1, sclk=0, copi=0 asynchronously; fifo_level=0; no done.
  - A new command after release produces a clean full frame.
- CLK_DIV=3, CS_SETUP=1, CS_HOLD=1: ncs low duration = 98 cycles, and every sclk phase is exactly 3 cycles.
- Boundary address 0x7F, data 0x00: frame 1,1111111,00000000 is sent unchanged and done pulses.
